// File: rtl/param_sync_fifo_if.sv
// Bus bundle for param_sync_fifo: write port, read port, flush and status.
//
// Handshake: a write is taken on a rising clock edge when wr_en_i is high and
// the FIFO is not full, or is full but a read is taken on the same edge. A
// read (pop) is taken when rd_en_i is high and the FIFO is not empty. There
// is no back-pressure wait. A request that cannot be taken is dropped and
// reported one cycle later on overflow_o / underflow_o. flush_i empties the
// FIFO and cancels any write or read requested in the same cycle.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rd_en_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rvalid_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [PTR_WIDTH:0]    count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output wr_en_i, wdata_i, rd_en_i, flush_i,
    input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    input  count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wdata_i, rd_en_i, flush_i,
    output rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    output count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with wrap-bit pointers, threshold flags,
// error pulses and a choice of registered or first-word-fall-through read.
// The interface instance must use the same DATA_WIDTH and DEPTH.
module param_sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 12,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  param_sync_fifo_if.slave bus
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AF_LVL = CW'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_LVL = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [PTR_WIDTH:0]   count;
  logic                 full;
  logic                 empty;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [PTR_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH-1:0] rd_addr;

  // Status derived only from pointer flops; the MSB is the wrap bit.
  assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

  assign bus.count_o        = count;
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_full_o  = (count >= AF_LVL);
  assign bus.almost_empty_o = (count <= AE_LVL);
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;

  // Accept/reject decisions and next pointer values; flush wins over requests.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_acc      = bus.rd_en_i && !empty && !bus.flush_i;
    wr_acc      = bus.wr_en_i && (!full || rd_acc) && !bus.flush_i;
    overflow_d  = bus.wr_en_i && full && !rd_acc && !bus.flush_i;
    underflow_d = bus.rd_en_i && empty && !bus.flush_i;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and error-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; never reset, pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) mem[wr_addr] <= bus.wdata_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is shown whenever the FIFO holds data; a read retires it.
    assign bus.rdata_o  = empty ? '0 : mem[rd_addr];
    assign bus.rvalid_o = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Popped entry lands in the output register; otherwise hold.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_acc;
      if (rd_acc) rdata_d = mem[rd_addr];
    end

    // Read data register with one-cycle valid pulse.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed + short random bench for param_sync_fifo (registered and FWFT).
module tb_param_sync_fifo;
  localparam int DW    = 12;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock and reset
  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) a_if ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b_if ();

  param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (a_if.slave)
  );

  param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b_if.slave)
  );

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rdata;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.wr_en_i = 1'b0; a_if.wdata_i = '0; a_if.rd_en_i = 1'b0; a_if.flush_i = 1'b0;
    b_if.wr_en_i = 1'b0; b_if.wdata_i = '0; b_if.rd_en_i = 1'b0; b_if.flush_i = 1'b0;
  endtask

  task automatic check_a(input logic ovf, input logic unf, input logic rv);
    int n;
    n = exp_q.size();
    chk("count", 32'(a_if.count_o), n);
    chk("full", 32'(a_if.full_o), 32'(n == DEPTH));
    chk("empty", 32'(a_if.empty_o), 32'(n == 0));
    chk("almost_full", 32'(a_if.almost_full_o), 32'(n >= DEPTH - 2));
    chk("almost_empty", 32'(a_if.almost_empty_o), 32'(n <= 2));
    chk("overflow", 32'(a_if.overflow_o), 32'(ovf));
    chk("underflow", 32'(a_if.underflow_o), 32'(unf));
    chk("rvalid", 32'(a_if.rvalid_o), 32'(rv));
    chk("rdata", 32'(a_if.rdata_o), 32'(exp_rdata));
  endtask

  // Driver: one clock of stimulus on the registered-read FIFO, with the
  // reference queue updated before the edge and outputs checked after it.
  task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic fl);
    int   n;
    logic rd_ok, wr_ok, ovf, unf, rv;
    n = exp_q.size();
    rd_ok = 1'b0; wr_ok = 1'b0; ovf = 1'b0; unf = 1'b0; rv = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      rd_ok = rd && (n != 0);
      wr_ok = wr && ((n != DEPTH) || rd_ok);
      ovf   = wr && (n == DEPTH) && !rd_ok;
      unf   = rd && (n == 0);
      if (rd_ok) begin
        exp_rdata = exp_q.pop_front();
        rv = 1'b1;
      end
      if (wr_ok) exp_q.push_back(wd);
    end
    a_if.wr_en_i = wr; a_if.wdata_i = wd; a_if.rd_en_i = rd; a_if.flush_i = fl;
    tick();
    idle_inputs();
    check_a(ovf, unf, rv);
  endtask

  // Reset with requests held active to show reset dominates them.
  task automatic do_reset(input logic wr, input logic rd, input logic fl);
    a_if.wr_en_i = wr; a_if.wdata_i = 12'h5A5; a_if.rd_en_i = rd; a_if.flush_i = fl;
    b_if.wr_en_i = wr; b_if.wdata_i = 12'h5A5; b_if.rd_en_i = rd; b_if.flush_i = fl;
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_rdata = '0;
    check_a(1'b0, 1'b0, 1'b0);
    chk("b_rst_count", 32'(b_if.count_o), 0);
    chk("b_rst_empty", 32'(b_if.empty_o), 1);
    chk("b_rst_rvalid", 32'(b_if.rvalid_o), 0);
    chk("b_rst_rdata", 32'(b_if.rdata_o), 0);
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    exp_rdata = '0;
    tick();
    do_reset(1'b1, 1'b1, 1'b1);

    // Fill to full with 0x001..0x010; threshold flags tracked every cycle.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    // Write while full drops the word and pulses overflow once.
    cycle(1'b1, 12'h3FF, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Read while empty, then read+write while empty.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 12'h055, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous read and write, then pop the new word last.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(12'h100 + i), 1'b0, 1'b0);
    cycle(1'b1, 12'h7E7, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_word", 32'(a_if.rdata_o), 32'h7E7);

    // Mixed traffic across pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'($urandom_range(0, 4095)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0);

    // Flush at count 9 with a concurrent write.
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'(12'h200 + i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(a_if.count_o), 9);
    cycle(1'b1, 12'h123, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(12'h300 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    do_reset(1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // First-word-fall-through instance.
    b_if.wr_en_i = 1'b1; b_if.wdata_i = 12'hABC;
    tick();
    idle_inputs();
    chk("b_fwft_rdata", 32'(b_if.rdata_o), 32'hABC);
    chk("b_fwft_rvalid", 32'(b_if.rvalid_o), 1);
    chk("b_fwft_empty", 32'(b_if.empty_o), 0);
    b_if.rd_en_i = 1'b1;
    tick();
    idle_inputs();
    chk("b_pop_empty", 32'(b_if.empty_o), 1);
    chk("b_pop_rvalid", 32'(b_if.rvalid_o), 0);
    b_if.wr_en_i = 1'b1; b_if.wdata_i = 12'h111;
    tick();
    b_if.wdata_i = 12'h222;
    tick();
    idle_inputs();
    chk("b_head1", 32'(b_if.rdata_o), 32'h111);
    chk("b_count2", 32'(b_if.count_o), 2);
    b_if.rd_en_i = 1'b1;
    tick();
    idle_inputs();
    chk("b_head2", 32'(b_if.rdata_o), 32'h222);
    b_if.rd_en_i = 1'b1;
    tick();
    idle_inputs();
    chk("b_drained", 32'(b_if.empty_o), 1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
